// File: rtl/multicycle_control.sv
// Multi-cycle control unit: accepts an opcode on a valid/ready handshake and
// sequences it through EXEC, MEM_WAIT and WB. It drives per-state datapath
// strobes, resolves branches from the comparator and aborts memory accesses
// that exceed MEM_TIMEOUT wait cycles.
module multicycle_control #(
    parameter int OP_W        = 4,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               equal,
    input  logic               mem_ack,
    output logic               RegDst,
    output logic               Branch,
    output logic               MemtoReg,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               ALUsrc,
    output logic               RegWrite,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               retire,
    output logic               illegal,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_WAIT, S_WB} state_e;

    typedef enum logic [3:0] {
        OC_ALU, OC_ADDI, OC_BNE, OC_BEQ, OC_MOVI, OC_SW, OC_LW, OC_NOP, OC_ILL
    } op_class_e;

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             timeout_q, timeout_d;
    logic [3:0]       op_lo;
    logic             hi_zero;
    op_class_e        op_class;

    // Classify the latched opcode; any nonzero bit above [3:0] makes it illegal
    always_comb begin
        op_lo    = op_q[3:0];
        hi_zero  = (op_q == OP_W'(op_lo));
        op_class = OC_ILL;
        if (hi_zero) begin
            case (op_lo)
                4'b0000, 4'b0001, 4'b0010, 4'b0011,
                4'b0100, 4'b0101, 4'b0110: op_class = OC_ALU;
                4'b0111:                   op_class = OC_ADDI;
                4'b1000:                   op_class = OC_BNE;
                4'b1001:                   op_class = OC_BEQ;
                4'b1010:                   op_class = OC_MOVI;
                4'b1011:                   op_class = OC_SW;
                4'b1100:                   op_class = OC_LW;
                4'b1111:                   op_class = OC_NOP;
                default:                   op_class = OC_ILL;
            endcase
        end
    end

    // State, latched opcode, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; a mem_ack in the limit cycle takes priority over the abort
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        cnt_inc   = cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_class)
                    OC_ALU, OC_ADDI, OC_MOVI: state_d = S_WB;
                    OC_SW, OC_LW: begin
                        state_d = S_MEM_WAIT;
                        cnt_d   = '0;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = (op_class == OC_LW) ? S_WB : S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state strobes: Moore on state/opcode, except Branch and the SW ack retire
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        RegDst      = 1'b0;
        Branch      = 1'b0;
        MemtoReg    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        ALUsrc      = 1'b0;
        RegWrite    = 1'b0;
        ALUOp       = '0;
        retire      = 1'b0;
        illegal     = 1'b0;
        timeout_err = timeout_q;
        if (state_q != S_IDLE) begin
            RegDst = (op_class == OC_ALU) || (op_class == OC_LW);
            ALUsrc = hi_zero && (op_lo inside {4'b0000, 4'b0001, 4'b0010, 4'b0111,
                                               4'b1010, 4'b1011, 4'b1100});
            ALUOp  = ALUOP_W'(op_lo);
        end
        case (state_q)
            S_EXEC: begin
                Branch  = ((op_class == OC_BEQ) && equal) ||
                          ((op_class == OC_BNE) && !equal);
                retire  = (op_class == OC_BEQ) || (op_class == OC_BNE) ||
                          (op_class == OC_NOP) || (op_class == OC_ILL);
                illegal = (op_class == OC_ILL);
            end
            S_MEM_WAIT: begin
                MemWrite = (op_class == OC_SW);
                MemRead  = (op_class == OC_LW);
                retire   = (op_class == OC_SW) && mem_ack;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (op_class == OC_LW);
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a vector table drives each
// instruction class, a scoreboard queue holds the expected strobes at retire,
// and hand-written sequences cover timeout, async reset and ignored handshakes.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] instr = '0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic       equal = 1'b0;
    logic       mem_ack = 1'b0;
    logic       RegDst, Branch, MemtoReg, MemRead, MemWrite, ALUsrc, RegWrite;
    logic [3:0] ALUOp;
    logic       retire, illegal, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic br, rw, m2r, rdst, asrc, ill;
        logic [3:0] aluop;
    } exp_t;

    typedef struct {
        logic [3:0] instr;
        logic       equal;
        int         ack_wait;  // MEM_WAIT cycles without ack before ack
        int         lat;       // negedge index (after accept) where retire is seen
        int         rd_cyc;
        int         wr_cyc;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[15];

    multicycle_control #(.OP_W(4), .ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .equal(equal), .mem_ack(mem_ack),
        .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg), .MemRead(MemRead),
        .MemWrite(MemWrite), .ALUsrc(ALUsrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .retire(retire), .illegal(illegal), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic eq, input int w,
                                input int lat, input int rd, input int wr,
                                input logic br, input logic rw, input logic m2r,
                                input logic rdst, input logic asrc, input logic ill);
        vec_t v;
        v.instr = op;  v.equal = eq;  v.ack_wait = w;
        v.lat = lat;   v.rd_cyc = rd; v.wr_cyc = wr;
        v.e.br = br;   v.e.rw = rw;   v.e.m2r = m2r;
        v.e.rdst = rdst; v.e.asrc = asrc; v.e.ill = ill; v.e.aluop = op;
        return v;
    endfunction

    // One instruction through the handshake; the scoreboard entry is popped at retire
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   c, rd, wr;
        bit   done;
        @(negedge clk);
        check({tag, ".ready"}, 32'(instr_ready), 32'd1);
        instr = v.instr; equal = v.equal; instr_valid = 1'b1; mem_ack = 1'b0;
        sb_q.push_back(v.e);
        @(posedge clk);
        c = 0; rd = 0; wr = 0; done = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            instr_valid = 1'b0;
            mem_ack = (c >= 2 + v.ack_wait);
            #1;
            if (MemRead)  rd++;
            if (MemWrite) wr++;
            if (retire) begin
                done = 1;
                if (sb_q.size() == 0) begin
                    check({tag, ".sb_empty"}, 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, ".Branch"},   32'(Branch),   32'(e.br));
                    check({tag, ".RegWrite"}, 32'(RegWrite), 32'(e.rw));
                    check({tag, ".MemtoReg"}, 32'(MemtoReg), 32'(e.m2r));
                    check({tag, ".RegDst"},   32'(RegDst),   32'(e.rdst));
                    check({tag, ".ALUsrc"},   32'(ALUsrc),   32'(e.asrc));
                    check({tag, ".illegal"},  32'(illegal),  32'(e.ill));
                    check({tag, ".ALUOp"},    32'(ALUOp),    32'(e.aluop));
                end
                check({tag, ".latency"}, 32'(c), 32'(v.lat));
            end
        end
        if (!done) check({tag, ".no_retire"}, 32'(c), 32'(v.lat));
        check({tag, ".memread_cycles"},  32'(rd), 32'(v.rd_cyc));
        check({tag, ".memwrite_cycles"}, 32'(wr), 32'(v.wr_cyc));
    endtask

    initial begin
        int wr, rt;
        //              op       eq   w   lat rd  wr  br rw m2r rdst asrc ill
        vecs[0]  = mk(4'b0110, 1'b0, 0,  2,  0,  0,  0, 1, 0,  1,   0,   0);
        vecs[1]  = mk(4'b0000, 1'b0, 0,  2,  0,  0,  0, 1, 0,  1,   1,   0);
        vecs[2]  = mk(4'b0111, 1'b0, 0,  2,  0,  0,  0, 1, 0,  0,   1,   0);
        vecs[3]  = mk(4'b1010, 1'b0, 0,  2,  0,  0,  0, 1, 0,  0,   1,   0);
        vecs[4]  = mk(4'b1001, 1'b1, 0,  1,  0,  0,  1, 0, 0,  0,   0,   0);
        vecs[5]  = mk(4'b1001, 1'b0, 0,  1,  0,  0,  0, 0, 0,  0,   0,   0);
        vecs[6]  = mk(4'b1000, 1'b1, 0,  1,  0,  0,  0, 0, 0,  0,   0,   0);
        vecs[7]  = mk(4'b1000, 1'b0, 0,  1,  0,  0,  1, 0, 0,  0,   0,   0);
        vecs[8]  = mk(4'b1111, 1'b0, 0,  1,  0,  0,  0, 0, 0,  0,   0,   0);
        vecs[9]  = mk(4'b1101, 1'b0, 0,  1,  0,  0,  0, 0, 0,  0,   0,   1);
        vecs[10] = mk(4'b1110, 1'b1, 0,  1,  0,  0,  0, 0, 0,  0,   0,   1);
        vecs[11] = mk(4'b1100, 1'b0, 3,  6,  4,  0,  0, 1, 1,  1,   1,   0);
        vecs[12] = mk(4'b1011, 1'b0, 0,  2,  0,  1,  0, 0, 0,  0,   1,   0);
        vecs[13] = mk(4'b1100, 1'b0, 0,  3,  1,  0,  0, 1, 1,  1,   1,   0);
        vecs[14] = mk(4'b1011, 1'b0, 14, 16, 0,  15, 0, 0, 0,  0,   1,   0);

        // Reset state
        #2;
        check("reset.ready", 32'(instr_ready), 32'd1);
        check("reset.outputs",
              32'({RegDst, Branch, MemtoReg, MemRead, MemWrite, ALUsrc, RegWrite,
                   ALUOp, retire, illegal, timeout_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // instr_valid raised during WB must not start a new instruction
        @(negedge clk);
        instr = 4'b0110; instr_valid = 1'b1; mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        check("wbpulse.retire",   32'(retire),   32'd1);
        check("wbpulse.RegWrite", 32'(RegWrite), 32'd1);
        instr = 4'b1111; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        check("wbpulse.ready_after", 32'(instr_ready), 32'd1);
        check("wbpulse.no_retire",   32'(retire),      32'd0);
        @(negedge clk);
        #1;
        check("wbpulse.still_idle", 32'({instr_ready, retire}), 32'b10);

        // SW with no ack: abort after 15 MEM_WAIT cycles, no retire
        check("timeout.pre", 32'(timeout_err), 32'd0);
        @(negedge clk);
        instr = 4'b1011; instr_valid = 1'b1; mem_ack = 1'b0;
        @(posedge clk);
        wr = 0; rt = 0;
        repeat (20) begin
            @(negedge clk);
            instr_valid = 1'b0;
            #1;
            if (MemWrite) wr++;
            if (retire)   rt++;
        end
        check("timeout.memwrite_cycles", 32'(wr), 32'd15);
        check("timeout.retires",         32'(rt), 32'd0);
        check("timeout.flag",            32'(timeout_err), 32'd1);
        check("timeout.ready",           32'(instr_ready), 32'd1);
        run_vec(vecs[8], "timeout_nop");
        check("timeout.sticky", 32'(timeout_err), 32'd1);

        // Async reset in the middle of an LW wait
        @(negedge clk);
        instr = 4'b1100; instr_valid = 1'b1; mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        check("areset.memread_before", 32'(MemRead), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.memread_drop", 32'(MemRead),     32'd0);
        check("areset.ready",        32'(instr_ready), 32'd1);
        check("areset.timeout_clr",  32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("areset.ready_after",   32'(instr_ready), 32'd1);
        check("areset.timeout_after", 32'(timeout_err), 32'd0);
        run_vec(vecs[0], "post_reset_alu");

        check("scoreboard.drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
